// File: rtl/neuron_pkg.sv
// Shared fixed-point constants and FSM encoding for the neuron MAC and its
// downstream activation stage.
package neuron_pkg;

   localparam int Q_W       = 16;
   localparam int FRAC_BITS = 8;
   localparam int PROD_W    = 2 * Q_W;

   localparam logic [Q_W-1:0] Q_ONE = 16'h0100;
   localparam logic [Q_W-1:0] Q_MAX = 16'h7FFF;
   localparam logic [Q_W-1:0] Q_MIN = 16'h8000;

   typedef enum logic [2:0] {
      IDLE,
      ACC,
      DRAIN,
      FINAL,
      OUT
   } state_t;

endpackage

// File: rtl/q_round_sat.sv
// Q16.16 accumulator to Q8.8: round half up (arithmetic shift), then saturate
// to the signed 16-bit range.
module q_round_sat
   import neuron_pkg::*;
#(
   parameter int ACC_W = 40
) (
   input  logic signed [ACC_W-1:0] acc,
   output logic        [Q_W-1:0]   q
);

   localparam logic signed [ACC_W-1:0] HALF  = ACC_W'(1 << (FRAC_BITS - 1));
   localparam logic signed [ACC_W-1:0] R_MAX = ACC_W'((1 << (Q_W - 1)) - 1);
   localparam logic signed [ACC_W-1:0] R_MIN = ~R_MAX;

   logic signed [ACC_W-1:0] r;

   // NOTE: every output of a combinational block gets a value on every path, so no latch is inferred.
   always_comb begin
      r = (acc + HALF) >>> FRAC_BITS;
      if (r > R_MAX) begin
         q = Q_MAX;
      end else if (r < R_MIN) begin
         q = Q_MIN;
      end else begin
         q = r[Q_W-1:0];
      end
   end

endmodule

// File: rtl/neuron_mac.sv
// Streaming multiply-accumulate for one neuron: N_INPUTS Q8.8 (x, w) pairs
// plus bias, rounded and saturated to Q8.8, with valid/ready on both sides.
module neuron_mac
   import neuron_pkg::*;
#(
   parameter int N_INPUTS = 16,
   parameter int ACC_W    = 40
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic signed [Q_W-1:0] in_x,
   input  logic signed [Q_W-1:0] in_w,
   input  logic signed [Q_W-1:0] in_bias,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic        [Q_W-1:0] out_sum,
   output logic                  busy
);

   localparam int               CNT_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(N_INPUTS - 1);

   state_t                   state;
   logic [CNT_W-1:0]         count;
   logic signed [PROD_W-1:0] prod;
   logic                     prod_v;
   logic signed [ACC_W-1:0]  acc;
   logic [Q_W-1:0]           q;
   logic                     xfer;

   assign in_ready = (state == IDLE) || (state == ACC);
   assign xfer     = in_valid && in_ready;

   q_round_sat #(.ACC_W(ACC_W)) u_round_sat (
      .acc (acc),
      .q   (q)
   );

   // NOTE: state is assigned with <= so every register samples the pre-edge values of its peers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         count     <= '0;
         out_valid <= 1'b0;
         out_sum   <= '0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE, ACC: begin
               if (xfer) begin
                  busy <= 1'b1;
                  if (count == LAST) begin
                     state <= DRAIN;
                     count <= '0;
                  end else begin
                     state <= ACC;
                     count <= count + CNT_W'(1);
                  end
               end
            end
            // Hold until the last product has left the multiplier register.
            DRAIN: begin
               if (!prod_v) state <= FINAL;
            end
            FINAL: begin
               out_sum   <= q;
               out_valid <= 1'b1;
               state     <= OUT;
            end
            OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prod   <= '0;
         prod_v <= 1'b0;
         acc    <= '0;
      end else begin
         prod_v <= xfer;
         if (xfer) prod <= PROD_W'(in_x) * PROD_W'(in_w);
         // The bias is pre-scaled to Q16.16 so it seeds the accumulator directly.
         if (xfer && state == IDLE) begin
            acc <= ACC_W'(in_bias) <<< FRAC_BITS;
         end else if (prod_v) begin
            acc <= acc + ACC_W'(prod);
         end
      end
   end

endmodule

// File: tb/tb_neuron_mac.sv
// Bench for neuron_mac (N_INPUTS=4): directed vectors, an arithmetic reference
// model drained by one compare process, and literal pins on the model.
module tb_neuron_mac;

   localparam int N = 4;

   typedef logic signed [15:0] vec_t [N];

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               in_valid = 1'b0;
   logic               in_ready;
   logic signed [15:0] in_x = '0;
   logic signed [15:0] in_w = '0;
   logic signed [15:0] in_bias = '0;
   logic               out_valid;
   logic               out_ready = 1'b1;
   logic [15:0]        out_sum;
   logic               busy;

   int          total = 0;
   int          bad = 0;
   logic [15:0] exp_q [$];

   neuron_mac #(.N_INPUTS(N), .ACC_W(40)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_x      (in_x),
      .in_w      (in_w),
      .in_bias   (in_bias),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%h want=%h", name, got, want);
      end
   endtask

   // Reference: exact integer dot product in Q16.16, floor((s + 0.5 LSB) / 256), clamp.
   function automatic logic [15:0] model(input vec_t x, input vec_t w, input logic signed [15:0] b);
      longint s;
      s = longint'(b) * 256;
      for (int i = 0; i < N; i++) s += longint'(x[i]) * longint'(w[i]);
      s = (s + 128) >>> 8;
      if (s > 32767) return 16'h7FFF;
      if (s < -32768) return 16'h8000;
      return 16'(s);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input vec_t x, input vec_t w, input logic signed [15:0] b,
                       input int max_gap, input int n_beats = N);
      for (int i = 0; i < n_beats; i++) begin
         int gap;
         int k;
         gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
         repeat (gap) begin
            in_valid = 1'b0;
            step();
         end
         in_valid = 1'b1;
         in_x     = x[i];
         in_w     = w[i];
         in_bias  = (i == 0) ? b : 16'sh5A5A;
         k = 0;
         while (!in_ready && k < 100) begin
            step();
            k++;
         end
         if (!in_ready) check("in_ready_timeout", 32'd0, 32'd1);
         step();
      end
      in_valid = 1'b0;
      if (n_beats == N) exp_q.push_back(model(x, w, b));
   endtask

   task automatic wait_done();
      int k;
      k = 0;
      while (!(out_valid && out_ready) && k < 50) begin
         step();
         k++;
      end
      if (!(out_valid && out_ready)) check("out_timeout", 32'd0, 32'd1);
      else step();
   endtask

   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) check("unexpected_out", 32'd1, 32'd0);
         else check("model", out_sum, exp_q.pop_front());
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t xa;
      vec_t wa;
      int   k;

      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_sum", out_sum, 0);
      check("rst_busy", busy, 0);
      rst_n = 1'b1;
      step();

      // 4 x (1.0 * 0.5) = 2.0, with exact output latency
      xa = '{default: 16'sh0100};
      wa = '{default: 16'sh0080};
      send(xa, wa, 16'sh0000, 0);
      check("busy_during", busy, 1);
      check("lat_edge0", out_valid, 0);
      step();
      check("lat_edge1", out_valid, 0);
      step();
      check("lat_edge2", out_valid, 0);
      step();
      check("lat_edge3", out_valid, 1);
      check("in_ready_out", in_ready, 0);
      wait_done();
      check("t1_lit", out_sum, 16'h0200);
      check("busy_after", busy, 0);
      check("in_ready_after", in_ready, 1);
      check("out_valid_after", out_valid, 0);

      // 4 x (1.0 * -1.0) + 1.0 = -3.0
      wa = '{default: 16'shFF00};
      send(xa, wa, 16'sh0100, 0);
      wait_done();
      check("t2_lit", out_sum, 16'hFD00);

      // saturation at both ends
      xa = '{default: 16'sh7FFF};
      wa = '{default: 16'sh7FFF};
      send(xa, wa, 16'sh0000, 0);
      wait_done();
      check("sat_pos_lit", out_sum, 16'h7FFF);
      wa = '{default: 16'sh8000};
      send(xa, wa, 16'sh0000, 0);
      wait_done();
      check("sat_neg_lit", out_sum, 16'h8000);

      // half-LSB rounding: +0.5 LSB rounds up, -0.5 LSB rounds to zero
      xa = '{16'sh0001, 16'sh0000, 16'sh0000, 16'sh0000};
      wa = '{16'sh0080, 16'sh0000, 16'sh0000, 16'sh0000};
      send(xa, wa, 16'sh0000, 0);
      wait_done();
      check("round_up_lit", out_sum, 16'h0001);
      wa = '{16'shFF80, 16'sh0000, 16'sh0000, 16'sh0000};
      send(xa, wa, 16'sh0000, 0);
      wait_done();
      check("round_neg_lit", out_sum, 16'h0000);

      // output backpressure with input gaps; in_valid during OUT is ignored
      xa = '{16'sh0180, 16'shFE40, 16'sh0033, 16'sh1000};
      wa = '{16'sh0200, 16'sh0100, 16'shFFF0, 16'sh0008};
      out_ready = 1'b0;
      send(xa, wa, 16'sh0010, 3);
      k = 0;
      while (!out_valid && k < 50) begin
         step();
         k++;
      end
      in_valid = 1'b1;
      in_x     = 16'sh1234;
      in_w     = 16'sh4321;
      in_bias  = 16'sh7777;
      repeat (5) begin
         check("bp_out_valid", out_valid, 1);
         check("bp_out_sum", out_sum, 16'h01CD);
         check("bp_in_ready", in_ready, 0);
         check("bp_busy", busy, 1);
         step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      wait_done();
      send(xa, wa, 16'sh0010, 0);
      wait_done();
      check("no_gap_lit", out_sum, 16'h01CD);

      // reset after 2 of 4 beats discards the partial sum
      xa = '{default: 16'sh0100};
      wa = '{default: 16'sh0080};
      send(xa, wa, 16'sh0040, 0, 2);
      step();
      rst_n = 1'b0;
      step();
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_in_ready", in_ready, 1);
      check("mid_rst_busy", busy, 0);
      rst_n = 1'b1;
      step();
      send(xa, wa, 16'sh0000, 0);
      wait_done();
      check("after_rst_lit", out_sum, 16'h0200);

      // mixed vectors against the model only
      for (int v = 0; v < 6; v++) begin
         for (int i = 0; i < N; i++) begin
            xa[i] = 16'($urandom);
            wa[i] = (v < 3) ? 16'($urandom_range(511, 0)) - 16'sd256 : 16'($urandom);
         end
         send(xa, wa, 16'($urandom), 2);
         wait_done();
      end

      check("queue_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
